// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, requester IDs and write-port reset values for the writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int XLEN         = 32;
  localparam int NREG         = 32;
  localparam int REG_W        = $clog2(NREG);
  localparam int STARVE_LIMIT = 3;
  localparam int CNT_W        = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  localparam logic [REG_W-1:0] WB_RST_ADDR = '0;
  localparam logic [XLEN-1:0]  WB_RST_DATA = '0;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write scoreboard: set on issue, cleared by a granted writeback.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_iss_valid,
  input  logic [REG_W-1:0] i_iss_rd,
  output logic             o_iss_ready,
  input  logic             i_clr_valid,
  input  logic [REG_W-1:0] i_clr_rd,
  input  logic [REG_W-1:0] i_rs1_addr,
  input  logic [REG_W-1:0] i_rs2_addr,
  output logic             o_rs1_busy,
  output logic             o_rs2_busy
);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;

  assign o_iss_ready = ~r_pending[i_iss_rd] | (i_iss_rd == '0);
  assign o_rs1_busy  = r_pending[i_rs1_addr] & (i_rs1_addr != '0);
  assign o_rs2_busy  = r_pending[i_rs2_addr] & (i_rs2_addr != '0);

  // x0 is never marked pending, so a clear of x0 is harmless.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_iss_valid && o_iss_ready && (i_iss_rd != '0))
      w_set_mask[i_iss_rd] = 1'b1;
    if (i_clr_valid)
      w_clr_mask[i_clr_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and LSU writebacks onto the single registered register-file write port.
// Define WB_ARB_RR_EN to replace the ALU-priority/starvation scheme with round-robin.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_wb_valid,
  input  logic [REG_W-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]  alu_wb_data,
  output logic             alu_wb_ready,
  input  logic             lsu_wb_valid,
  input  logic [REG_W-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]  lsu_wb_data,
  output logic             lsu_wb_ready,
  input  logic             iss_valid,
  input  logic [REG_W-1:0] iss_rd,
  output logic             iss_ready,
  input  logic [REG_W-1:0] rs1_addr,
  input  logic [REG_W-1:0] rs2_addr,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rf_we,
  output logic [REG_W-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata
);

  // Handshake: a writeback transfers when valid && ready; a losing requester holds
  // valid, rd and data stable until it sees ready.
  logic             w_contend;
  req_id_e          w_win;
  logic             w_fire;
  logic [REG_W-1:0] w_rd;
  logic [XLEN-1:0]  w_data;

  assign w_contend = alu_wb_valid & lsu_wb_valid;

`ifdef WB_ARB_RR_EN
  req_id_e r_rr_last;

  always_comb begin
    w_win = lsu_wb_valid ? REQ_LSU : REQ_ALU;
    if (w_contend)
      w_win = (r_rr_last == REQ_ALU) ? REQ_LSU : REQ_ALU;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_rr_last <= REQ_ALU;
    else if (w_contend) r_rr_last <= w_win;
  end
`else
  logic [CNT_W-1:0] r_starve_cnt;

  always_comb begin
    w_win = lsu_wb_valid ? REQ_LSU : REQ_ALU;
    if (w_contend)
      w_win = (r_starve_cnt == STARVE_MAX) ? REQ_LSU : REQ_ALU;
  end

  // Counts consecutive contention cycles the ALU has won.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_starve_cnt <= '0;
    else if (w_contend && w_win == REQ_ALU) r_starve_cnt <= r_starve_cnt + 1'b1;
    else                                    r_starve_cnt <= '0;
  end
`endif

  assign alu_wb_ready = alu_wb_valid & (w_win == REQ_ALU);
  assign lsu_wb_ready = lsu_wb_valid & (w_win == REQ_LSU);
  assign w_fire       = alu_wb_ready | lsu_wb_ready;
  assign w_rd         = (w_win == REQ_LSU) ? lsu_wb_rd   : alu_wb_rd;
  assign w_data       = (w_win == REQ_LSU) ? lsu_wb_data : alu_wb_data;

  // Writes to x0 are consumed without touching the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= WB_RST_ADDR;
      rf_wdata <= WB_RST_DATA;
    end else begin
      rf_we <= w_fire && (w_rd != '0);
      if (w_fire && (w_rd != '0)) begin
        rf_waddr <= w_rd;
        rf_wdata <= w_data;
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .o_iss_ready (iss_ready),
    .i_clr_valid (w_fire),
    .i_clr_rd    (w_rd),
    .i_rs1_addr  (rs1_addr),
    .i_rs2_addr  (rs2_addr),
    .o_rs1_busy  (rs1_busy),
    .o_rs2_busy  (rs2_busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized run
// against a behavioural model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             alu_wb_valid = 1'b0;
  logic [4:0]       alu_wb_rd = '0;
  logic [31:0]      alu_wb_data = '0;
  logic             alu_wb_ready;
  logic             lsu_wb_valid = 1'b0;
  logic [4:0]       lsu_wb_rd = '0;
  logic [31:0]      lsu_wb_data = '0;
  logic             lsu_wb_ready;
  logic             iss_valid = 1'b0;
  logic [4:0]       iss_rd = '0;
  logic             iss_ready;
  logic [4:0]       rs1_addr = '0;
  logic [4:0]       rs2_addr = '0;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_pend;
  int          m_alu_streak;
  logic        m_rr_last;
  logic [36:0] exp_q[$];

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rd(lsu_wb_rd), .lsu_wb_data(lsu_wb_data),
    .lsu_wb_ready(lsu_wb_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic idle_inputs();
    alu_wb_valid = 1'b0;
    lsu_wb_valid = 1'b0;
    iss_valid    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pend       = '0;
    m_alu_streak = 0;
    m_rr_last    = 1'b0;
    exp_q.delete();
  endtask

  // Behavioural grant decision from the arbitration rules.
  task automatic model_grant(input logic av, input logic lv, output logic ga, output logic gl);
    if (av && lv) begin
`ifdef WB_ARB_RR_EN
      gl = (m_rr_last == 1'b0);
`else
      gl = (m_alu_streak >= STARVE_LIMIT);
`endif
      ga = !gl;
    end else begin
      ga = av;
      gl = lv;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_port: got we=%0b addr=%0d data=%0h expected 0/0/0", rf_we, rf_waddr, rf_wdata);
    end
    rs1_addr = 5'($urandom_range(1, 31));
    rs2_addr = 5'($urandom_range(1, 31));
    iss_rd   = 5'($urandom_range(1, 31));
    #1;
    checks++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0 || iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_sb: got rs1=%0b rs2=%0b iss_ready=%0b expected 0/0/1", rs1_busy, rs2_busy, iss_ready);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu_only();
    @(negedge clk);
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (alu_wb_ready !== 1'b1 || lsu_wb_ready !== 1'b0) begin
      errors++;
      $display("FAIL alu_only_ready: got alu=%0b lsu=%0b expected 1/0", alu_wb_ready, lsu_wb_ready);
    end
    @(posedge clk); #1;
    alu_wb_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_only_write: got we=%0b addr=%0d data=%0h expected 1/5/deadbeef", rf_we, rf_waddr, rf_wdata);
    end
    @(posedge clk); #1;
    checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_only_hold: got we=%0b addr=%0d data=%0h expected 0/5/deadbeef", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_contention();
    int alu_rds[5] = '{1, 2, 3, 4, 5};
    int lsu_rds[3] = '{7, 8, 9};
    int exp_lsu[5];
    int exp_addr[5];
    int ncyc;
    int ai = 0;
    int li = 0;
    logic [31:0] exp_data;
`ifdef WB_ARB_RR_EN
    ncyc     = 4;
    exp_lsu  = '{1, 0, 1, 0, 0};
    exp_addr = '{7, 1, 8, 2, 0};
`else
    ncyc     = 5;
    exp_lsu  = '{0, 0, 0, 1, 0};
    exp_addr = '{1, 2, 3, 7, 4};
`endif
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      alu_wb_valid = 1'b1; alu_wb_rd = 5'(alu_rds[ai]); alu_wb_data = 32'hA000_0000 + 32'(alu_rds[ai]);
      lsu_wb_valid = 1'b1; lsu_wb_rd = 5'(lsu_rds[li]); lsu_wb_data = 32'hB000_0000 + 32'(lsu_rds[li]);
      #1;
      checks++;
      if (lsu_wb_ready !== exp_lsu[c][0] || alu_wb_ready !== !exp_lsu[c][0]) begin
        errors++;
        $display("FAIL contention_grant[%0d]: got alu=%0b lsu=%0b expected lsu=%0d", c, alu_wb_ready, lsu_wb_ready, exp_lsu[c]);
      end
      exp_data = (exp_lsu[c] != 0) ? 32'hB000_0000 + 32'(exp_addr[c]) : 32'hA000_0000 + 32'(exp_addr[c]);
      @(posedge clk); #1;
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'(exp_addr[c]) || rf_wdata !== exp_data) begin
        errors++;
        $display("FAIL contention_write[%0d]: got we=%0b addr=%0d data=%0h expected 1/%0d/%0h", c, rf_we, rf_waddr, rf_wdata, exp_addr[c], exp_data);
      end
      if (exp_lsu[c] != 0) li++;
      else                 ai++;
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    do_reset();
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL sb_issue_ready: got %0b expected 1", iss_ready);
    end
    @(negedge clk);
    iss_valid = 1'b0; rs1_addr = 5'd9; rs2_addr = 5'd10;
    #1;
    checks++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0 || iss_ready !== 1'b0) begin
      errors++;
      $display("FAIL sb_pending: got rs1=%0b rs2=%0b iss_ready=%0b expected 1/0/0", rs1_busy, rs2_busy, iss_ready);
    end
    @(negedge clk);
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd9; lsu_wb_data = 32'h0000_0099;
    #1;
    checks++;
    if (lsu_wb_ready !== 1'b1 || rs1_busy !== 1'b1) begin
      errors++;
      $display("FAIL sb_grant_cycle: got lsu_ready=%0b rs1=%0b expected 1/1", lsu_wb_ready, rs1_busy);
    end
    @(posedge clk); #1;
    lsu_wb_valid = 1'b0;
    #1;
    checks++;
    if (rs1_busy !== 1'b0 || iss_ready !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99) begin
      errors++;
      $display("FAIL sb_cleared: got rs1=%0b iss_ready=%0b we=%0b addr=%0d data=%0h expected 0/1/1/9/99", rs1_busy, iss_ready, rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'h1234;
    iss_valid = 1'b1; iss_rd = 5'd0; rs1_addr = 5'd0;
    #1;
    checks++;
    if (alu_wb_ready !== 1'b1 || iss_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready: got alu_ready=%0b iss_ready=%0b expected 1/1", alu_wb_ready, iss_ready);
    end
    @(posedge clk); #1;
    idle_inputs();
    #1;
    checks++;
    if (rf_we !== 1'b0 || rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL x0_no_write: got we=%0b rs1_busy=%0b expected 0/0", rf_we, rs1_busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd3;
    @(negedge clk);
    iss_rd = 5'd6;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'h55;
    @(posedge clk); #1;
    idle_inputs();
    rs1_addr = 5'd3; rs2_addr = 5'd6;
    #1;
    checks++;
    if (rf_we !== 1'b1 || rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_before: got we=%0b rs1=%0b rs2=%0b expected 1/1/1", rf_we, rs1_busy, rs2_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rf_we !== 1'b0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got we=%0b rs1=%0b rs2=%0b expected 0/0/0", rf_we, rs1_busy, rs2_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    iss_rd = 5'd3;
    #1;
    checks++;
    if (iss_ready !== 1'b1 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_after: got iss_ready=%0b addr=%0d data=%0h expected 1/0/0", iss_ready, rf_waddr, rf_wdata);
    end
    m_pend = '0; m_alu_streak = 0; m_rr_last = 1'b0;
  endtask

  task automatic test_random();
    logic        ga, gl, hold_a, hold_l, exp_we, exp_ir, exp_b1, exp_b2;
    logic [31:0] set_m, clr_m;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic [36:0] exp_w;
    do_reset();
    hold_a = 1'b0;
    hold_l = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!hold_a) begin
        alu_wb_valid = ($urandom_range(0, 3) != 0);
        alu_wb_rd    = 5'($urandom_range(0, 7));
        alu_wb_data  = $urandom;
      end
      if (!hold_l) begin
        lsu_wb_valid = ($urandom_range(0, 3) != 0);
        lsu_wb_rd    = 5'($urandom_range(0, 7));
        lsu_wb_data  = $urandom;
      end
      iss_valid = ($urandom_range(0, 1) != 0);
      iss_rd    = 5'($urandom_range(0, 7));
      rs1_addr  = 5'($urandom_range(0, 7));
      rs2_addr  = 5'($urandom_range(0, 7));
      #1;
      model_grant(alu_wb_valid, lsu_wb_valid, ga, gl);
      exp_ir = !m_pend[iss_rd] || (iss_rd == 5'd0);
      exp_b1 = m_pend[rs1_addr] && (rs1_addr != 5'd0);
      exp_b2 = m_pend[rs2_addr] && (rs2_addr != 5'd0);
      checks++;
      if (alu_wb_ready !== ga || lsu_wb_ready !== gl) begin
        errors++;
        $display("FAIL rand_grant[%0d]: got alu=%0b lsu=%0b expected %0b/%0b", n, alu_wb_ready, lsu_wb_ready, ga, gl);
      end
      checks++;
      if (iss_ready !== exp_ir || rs1_busy !== exp_b1 || rs2_busy !== exp_b2) begin
        errors++;
        $display("FAIL rand_sb[%0d]: got ir=%0b b1=%0b b2=%0b expected %0b/%0b/%0b", n, iss_ready, rs1_busy, rs2_busy, exp_ir, exp_b1, exp_b2);
      end
      // Model update for the coming edge.
      w_rd   = gl ? lsu_wb_rd : alu_wb_rd;
      w_data = gl ? lsu_wb_data : alu_wb_data;
      exp_we = (ga || gl) && (w_rd != 5'd0);
      if (exp_we) exp_q.push_back({w_rd, w_data});
      set_m = '0;
      clr_m = '0;
      if (iss_valid && exp_ir && iss_rd != 5'd0) set_m[iss_rd] = 1'b1;
      if (ga || gl) clr_m[w_rd] = 1'b1;
      if (alu_wb_valid && lsu_wb_valid) begin
        m_alu_streak = ga ? m_alu_streak + 1 : 0;
        m_rr_last    = gl;
      end else begin
        m_alu_streak = 0;
      end
      hold_a = alu_wb_valid && !ga;
      hold_l = lsu_wb_valid && !gl;
      @(posedge clk); #1;
      m_pend = (m_pend & ~clr_m) | set_m;
      checks++;
      if (rf_we !== exp_we) begin
        errors++;
        $display("FAIL rand_we[%0d]: got %0b expected %0b", n, rf_we, exp_we);
      end
      if (exp_we && exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        checks++;
        if ({rf_waddr, rf_wdata} !== exp_w) begin
          errors++;
          $display("FAIL rand_write[%0d]: got addr=%0d data=%0h expected addr=%0d data=%0h", n, rf_waddr, rf_wdata, exp_w[36:32], exp_w[31:0]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_contention();
    test_scoreboard();
    test_x0();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
